// File: rtl/ble_tx_pkg.sv
// Shared types and constants for the BLE GFSK-style transmit modulator.
// Holds the frame FSM encoding, frame constants, phase step and the I/Q LUT.
package ble_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        ACCESS,
        PAYLOAD
    } tx_state_t;

    localparam logic [31:0] ACCESS_ADDR   = 32'h8E89BED6;
    // Sent LSB first, so the air sequence is 0,1,0,1,0,1,0,1.
    localparam logic [7:0]  PREAMBLE_BITS = 8'b1010_1010;

    localparam logic [4:0]  PRE_LAST  = 5'd7;
    localparam logic [4:0]  AA_LAST   = 5'd31;
    localparam logic [4:0]  BYTE_LAST = 5'd7;

    localparam int PHASE_QUARTER = 64;

    function automatic logic [7:0] phase_step(int sr);
        return 8'(PHASE_QUARTER / sr);
    endfunction

    // Cosine of k*22.5 degrees in Q10.
    function automatic int cos_q10(logic [3:0] k);
        case (k)
            4'd0:    return 1024;
            4'd1:    return 946;
            4'd2:    return 724;
            4'd3:    return 392;
            4'd4:    return 0;
            4'd5:    return -392;
            4'd6:    return -724;
            4'd7:    return -946;
            4'd8:    return -1024;
            4'd9:    return -946;
            4'd10:   return -724;
            4'd11:   return -392;
            4'd12:   return 0;
            4'd13:   return 392;
            4'd14:   return 724;
            default: return 946;
        endcase
    endfunction

    // Round-half-away scaling of a Q10 value to the output amplitude.
    function automatic int lut_scale(int v, int amp);
        if (v >= 0)
            return (v * amp + 512) / 1024;
        else
            return -((-v * amp + 512) / 1024);
    endfunction

endpackage

// File: rtl/ble_whitener.sv
// BLE data whitening LFSR (x^7 + x^4 + 1), seeded from the channel index.
// Only compiled in when BLE_TX_WHITEN_EN is defined.
`ifdef BLE_TX_WHITEN_EN
module ble_whitener (
    input  logic       clk,
    input  logic       resetn,
    input  logic       load,
    input  logic [5:0] channel,
    input  logic       step,
    output logic       bit_out
);

    logic [6:0] lfsr;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            lfsr <= '0;
        end else if (load) begin
            // Position 0 is 1, positions 1..6 take channel MSB..LSB.
            lfsr <= {channel[0], channel[1], channel[2],
                     channel[3], channel[4], channel[5], 1'b1};
        end else if (step) begin
            lfsr <= {lfsr[5], lfsr[4], lfsr[3] ^ lfsr[6],
                     lfsr[2], lfsr[1], lfsr[0], lfsr[6]};
        end
    end

    assign bit_out = lfsr[6];

endmodule
`endif

// File: rtl/ble_tx_mod.sv
// BLE frame modulator: preamble, access address and payload to I/Q samples.
// Payload whitening is included when BLE_TX_WHITEN_EN is defined.
module ble_tx_mod
    import ble_tx_pkg::*;
#(
    parameter int SAMPLE_RATE = 16,
    parameter int DATA_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  en,
    input  logic [5:0]            channel,
    input  logic                  tx_start,
    input  logic [7:0]            tx_len,
    input  logic [7:0]            byte_data,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic [DATA_WIDTH-1:0] i_out,
    output logic [DATA_WIDTH-1:0] q_out,
    output logic                  tx_symbol,
    output logic                  tx_symbol_clk,
    output logic                  busy,
    output logic                  done,
    output logic                  underrun
);

    localparam int              CW       = $clog2(SAMPLE_RATE);
    localparam int              AMP      = (1 << (DATA_WIDTH - 1)) - 1;
    localparam logic [7:0]      STEP     = phase_step(SAMPLE_RATE);
    localparam logic [CW-1:0]   CNT_LAST = CW'(SAMPLE_RATE - 1);
    localparam logic [CW-1:0]   CNT_HALF = CW'(SAMPLE_RATE / 2);

    tx_state_t       state;
    tx_state_t       state_n;
    logic [CW-1:0]   sample_cnt;
    logic [4:0]      bit_cnt;
    logic [7:0]      len_r;
    logic [7:0]      fetch_left;
    logic [7:0]      pay_left;
    logic [7:0]      hold_data;
    logic            hold_full;
    logic [7:0]      shift;
    logic [7:0]      phase;
    logic [3:0]      idx;
    logic [DATA_WIDTH-1:0] i_lut;
    logic [DATA_WIDTH-1:0] q_lut;

    logic start;
    logic take;
    logic bit_end;
    logic seg_end;
    logic load_byte;
    logic finish;
    logic abort;
    logic wbit;

    assign busy          = (state != IDLE);
    assign start         = (state == IDLE) && tx_start;
    assign byte_ready    = en && busy && !hold_full && (fetch_left != 8'd0);
    assign take          = byte_valid && byte_ready;
    assign bit_end       = en && busy && (sample_cnt == CNT_LAST);
    assign tx_symbol_clk = busy && (sample_cnt < CNT_HALF);

`ifdef BLE_TX_WHITEN_EN
    logic wstep;
    assign wstep = bit_end && (state == PAYLOAD);

    ble_whitener u_whiten (
        .clk     (clk),
        .resetn  (resetn),
        .load    (start),
        .channel (channel),
        .step    (wstep),
        .bit_out (wbit)
    );
`else
    logic unused_ch;
    assign unused_ch = ^channel;
    assign wbit      = 1'b0;
`endif

    always_comb begin
        tx_symbol = 1'b0;
        unique case (state)
            PREAMBLE: tx_symbol = PREAMBLE_BITS[bit_cnt[2:0]];
            ACCESS:   tx_symbol = ACCESS_ADDR[bit_cnt];
            PAYLOAD:  tx_symbol = shift[bit_cnt[2:0]] ^ wbit;
            default:  tx_symbol = 1'b0;
        endcase
    end

    always_comb begin
        idx   = phase[7:4];
        i_lut = DATA_WIDTH'(lut_scale(cos_q10(idx), AMP));
        q_lut = DATA_WIDTH'(lut_scale(cos_q10(idx - 4'd4), AMP));
    end

    always_comb begin
        state_n   = state;
        seg_end   = 1'b0;
        load_byte = 1'b0;
        finish    = 1'b0;
        abort     = 1'b0;
        unique case (state)
            IDLE: begin
                if (tx_start)
                    state_n = PREAMBLE;
            end
            PREAMBLE: begin
                if (bit_end && bit_cnt == PRE_LAST) begin
                    seg_end = 1'b1;
                    state_n = ACCESS;
                end
            end
            ACCESS: begin
                if (bit_end && bit_cnt == AA_LAST) begin
                    seg_end = 1'b1;
                    if (len_r == 8'd0) begin
                        finish = 1'b1;
                    end else if (hold_full) begin
                        load_byte = 1'b1;
                        state_n   = PAYLOAD;
                    end else begin
                        abort = 1'b1;
                    end
                end
            end
            PAYLOAD: begin
                if (bit_end && bit_cnt == BYTE_LAST) begin
                    seg_end = 1'b1;
                    if (pay_left == 8'd1)
                        finish = 1'b1;
                    else if (hold_full)
                        load_byte = 1'b1;
                    else
                        abort = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (finish || abort)
            state_n = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sample_cnt <= '0;
            bit_cnt    <= '0;
            len_r      <= '0;
            fetch_left <= '0;
            pay_left   <= '0;
            hold_data  <= '0;
            hold_full  <= 1'b0;
            shift      <= '0;
            phase      <= '0;
            i_out      <= '0;
            q_out      <= '0;
            done       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            done     <= finish;
            underrun <= abort;
            if (take) begin
                hold_data  <= byte_data;
                hold_full  <= 1'b1;
                fetch_left <= fetch_left - 1'b1;
            end
            if (state == IDLE) begin
                sample_cnt <= '0;
                bit_cnt    <= '0;
                phase      <= '0;
                i_out      <= '0;
                q_out      <= '0;
                hold_full  <= 1'b0;
                if (tx_start) begin
                    len_r      <= tx_len;
                    fetch_left <= tx_len;
                end
            end else if (en) begin
                sample_cnt <= sample_cnt + 1'b1;
                phase      <= tx_symbol ? phase + STEP : phase - STEP;
                i_out      <= i_lut;
                q_out      <= q_lut;
                if (bit_end)
                    bit_cnt <= seg_end ? 5'd0 : bit_cnt + 5'd1;
                if (load_byte) begin
                    shift     <= hold_data;
                    hold_full <= 1'b0;
                    pay_left  <= (state == ACCESS) ? len_r : pay_left - 1'b1;
                end
                // Leaving the frame silences the carrier immediately.
                if (finish || abort) begin
                    i_out     <= '0;
                    q_out     <= '0;
                    hold_full <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ble_tx_mod.sv
// Directed bench for ble_tx_mod: frame bits, I/Q phase, pause, underrun,
// zero-length frame, payload XOR across frames and mid-frame reset.
module tb_ble_tx_mod;

    localparam logic [31:0] AA = 32'h8E89BED6;

    logic       clk;
    logic       resetn;
    logic       en;
    logic [5:0] channel;
    logic       tx_start;
    logic [7:0] tx_len;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;
    logic [3:0] i_out;
    logic [3:0] q_out;
    logic       tx_symbol;
    logic       tx_symbol_clk;
    logic       busy;
    logic       done;
    logic       underrun;

    ble_tx_mod #(.SAMPLE_RATE(16), .DATA_WIDTH(4)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .en            (en),
        .channel       (channel),
        .tx_start      (tx_start),
        .tx_len        (tx_len),
        .byte_data     (byte_data),
        .byte_valid    (byte_valid),
        .byte_ready    (byte_ready),
        .i_out         (i_out),
        .q_out         (q_out),
        .tx_symbol     (tx_symbol),
        .tx_symbol_clk (tx_symbol_clk),
        .busy          (busy),
        .done          (done),
        .underrun      (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_total++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    // round(7*cos(k*22.5deg)) as 4-bit two's complement
    logic [3:0] cos_t [16] = '{4'h7, 4'h6, 4'h5, 4'h3, 4'h0, 4'hD, 4'hB, 4'hA,
                               4'h9, 4'hA, 4'hB, 4'hD, 4'h0, 4'h3, 4'h5, 4'h6};

    function automatic logic [3:0] sin_of(logic [3:0] k);
        return cos_t[4'(k + 4'd12)];
    endfunction

    logic [7:0]  pay [2];
    logic [7:0]  feed [$];
    logic        acc;
    logic        en_s;
    int          done_cyc;
    int          under_cyc;
    logic [63:0] bits_rx;
    logic [7:0]  w0;

    function automatic logic exp_bit(int k);
        if (k < 8)
            return k[0];
        else if (k < 40)
            return AA[k-8];
        else
            return pay[(k-40)/8][(k-40)%8];
    endfunction

    task automatic tick();
        byte_valid = (feed.size() != 0);
        byte_data  = (feed.size() != 0) ? feed[0] : 8'h00;
        @(negedge clk);
        acc  = byte_valid && byte_ready;
        en_s = en;
        @(posedge clk);
        #1;
        if (acc)
            void'(feed.pop_front());
    endtask

    task automatic run_frame(input logic [7:0] len, input int pause_at,
                             input int reset_at, input bit hand);
        int n;
        int cyc;
        int pcnt;
        logic [7:0] ph;
        logic [7:0] prev;
        logic [3:0] ei;
        logic [3:0] eq;
        n = 0; cyc = 0; pcnt = 0; ph = 8'd0; ei = 4'd0; eq = 4'd0;
        bits_rx = '0; done_cyc = -1; under_cyc = -1;
        channel = 6'd37; tx_len = len; tx_start = 1'b1; en = 1'b1;
        tick();
        tx_start = 1'b0;
        check("start_busy", 64'(busy), 64'(1));
        while (cyc < 2000) begin
            en = !(n == pause_at && pcnt < 100);
            if (!en)
                pcnt++;
            tx_start = (n == 300);
            tx_len   = (n == 300) ? 8'd9 : len;
            if (n == reset_at)
                resetn = 1'b0;
            tick();
            cyc++;
            tx_start = 1'b0;
            tx_len   = len;
            if (!resetn) begin
                check("rst_mid_frame",
                      64'({busy, done, underrun, tx_symbol, tx_symbol_clk,
                           byte_ready, i_out, q_out}), 64'(0));
                resetn = 1'b1;
                feed.delete();
                return;
            end
            if (en_s) begin
                n++;
                prev = ph;
                ph = exp_bit((n - 1) / 16) ? ph + 8'd4 : ph - 8'd4;
                ei = cos_t[prev[7:4]];
                eq = sin_of(prev[7:4]);
                if (n % 16 == 8) begin
                    bits_rx[n/16] = tx_symbol;
                    if (n <= 640)
                        check("iq_model", 64'({i_out, q_out}), 64'({ei, eq}));
                end
                if (hand) begin
                    case (n)
                        7:   check("symclk_hi", 64'(tx_symbol_clk), 64'(1));
                        8:   check("symclk_lo", 64'(tx_symbol_clk), 64'(0));
                        9:   check("iq_n9", 64'({i_out, q_out}), 64'(8'h5B));
                        17:  check("iq_n17", 64'({i_out, q_out}), 64'(8'h09));
                        33:  check("iq_n33", 64'({i_out, q_out}), 64'(8'h70));
                        129: check("iq_n129", 64'({i_out, q_out}), 64'(8'h70));
                        177: check("iq_n177", 64'({i_out, q_out}), 64'(8'h07));
                        default: ;
                    endcase
                end
            end else if (pcnt == 100) begin
                check("freeze",
                      64'({busy, tx_symbol, tx_symbol_clk, i_out, q_out}),
                      64'({1'b1, exp_bit(n / 16), 1'b0, ei, eq}));
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (underrun) begin
                under_cyc = cyc;
                break;
            end
        end
        feed.delete();
    endtask

    initial begin
        resetn = 1'b0; en = 1'b0; tx_start = 1'b0; channel = 6'd0;
        tx_len = 8'd0; byte_valid = 1'b0; byte_data = 8'd0;
        repeat (3) tick();
        check("reset_state",
              64'({busy, done, underrun, tx_symbol, tx_symbol_clk,
                   byte_ready, i_out, q_out}), 64'(0));
        resetn = 1'b1;
        en = 1'b1;
        tick();
        check("idle_outs",
              64'({busy, done, underrun, tx_symbol, tx_symbol_clk,
                   byte_ready, i_out, q_out}), 64'(0));

        pay[0] = 8'hA5; pay[1] = 8'h00;
        feed.push_back(8'hA5);
        run_frame(8'd1, -1, -1, 1'b1);
        check("s1_done_cyc", 64'(done_cyc), 64'(768));
        check("s1_preamble", 64'(bits_rx[7:0]), 64'(8'hAA));
        check("s1_access", 64'(bits_rx[39:8]), 64'(32'h8E89BED6));
`ifndef BLE_TX_WHITEN_EN
        check("s1_payload", 64'(bits_rx[47:40]), 64'(8'hA5));
`endif
        tick();
        check("s1_done_pulse", 64'({done, busy, i_out, q_out}), 64'(0));

        feed.push_back(8'hA5);
        run_frame(8'd1, 200, -1, 1'b0);
        check("s4_done_cyc", 64'(done_cyc), 64'(868));

        pay[0] = 8'h3C;
        feed.push_back(8'h3C);
        run_frame(8'd2, -1, -1, 1'b0);
        check("s2_under_cyc", 64'(under_cyc), 64'(768));
        check("s2_no_done", 64'(done_cyc), 64'(-1));
        check("s2_after", 64'({busy, done, i_out, q_out}), 64'(0));
        tick();
        check("s2_pulse", 64'({underrun, done, busy}), 64'(0));

        run_frame(8'd0, -1, -1, 1'b0);
        check("len0_done_cyc", 64'(done_cyc), 64'(640));

        pay[0] = 8'h00;
        feed.push_back(8'h00);
        run_frame(8'd1, -1, -1, 1'b0);
        check("s5_done_a", 64'(done_cyc), 64'(768));
        w0 = bits_rx[47:40];
        pay[0] = 8'hFF;
        feed.push_back(8'hFF);
        run_frame(8'd1, -1, -1, 1'b0);
        check("s5_done_b", 64'(done_cyc), 64'(768));
        check("s5_xor", 64'(w0 ^ bits_rx[47:40]), 64'(8'hFF));

        pay[0] = 8'h5A;
        feed.push_back(8'h5A);
        run_frame(8'd1, -1, 700, 1'b0);
        repeat (20) tick();
        check("post_rst_quiet", 64'({done, underrun, busy, i_out, q_out}),
              64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
